// File: rtl/ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl -- instruction-fetch sequencer for a single-cycle-latency IMEM.
//
// Owns the program counter, issues at most one IMEM read per cycle, and
// buffers returned words in a 2-entry FIFO that drains to decode through a
// valid/ready handshake. A redirect flushes the FIFO, squashes the in-flight
// read and restarts fetch at the (aligned, wrapped) target in the same cycle.
//
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   : a redirect with target[1:0] != 0 flushes, issues nothing,
//               raises the sticky fault flag and parks the block in HALT.
//   undefined : target[1:0] is forced to 00, fault is constant 0.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   mem_en          IMEM read strobe for this cycle
//   mem_addr        IMEM byte address (word aligned)
//   mem_rdata       IMEM data, valid the cycle after mem_en
//   redirect_valid  single-cycle fetch restart request
//   redirect_pc     restart target
//   inst_valid      FIFO head valid
//   inst_ready      decode accepts the head
//   inst_data       FIFO head instruction (0 when empty)
//   inst_pc         FIFO head address (0 when empty)
//   fault           sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault
);

  // Word-aligned address within IMEM; applying it gives the modulo wrap.
  localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1) & 32'hFFFF_FFFC;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  occ;
  logic        vld_p1;
  logic [31:0] pc_p1;
  logic [31:0] q_data [2];
  logic [31:0] q_pc   [2];
  logic        fault_r;

  logic        pop;
  logic        redir;
  logic        misalign;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;
  logic [1:0]  occ_pop;
  logic [2:0]  need;
  logic        credit;

  assign pop       = inst_valid & inst_ready;
  assign redir     = redirect_valid & (state == RUN);
  assign redir_tgt = redirect_pc & PC_MASK;
  assign occ_pop   = occ - {1'b0, pop};
  assign need      = {1'b0, occ} + {2'b00, vld_p1};
  // Issue only if the word can land in the FIFO even if decode stalls.
  assign credit    = need < (3'd2 + {2'b00, pop});
  assign next_pc   = (mem_addr + 32'd4) & PC_MASK;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign misalign = (redirect_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Stage p0: read issue. A redirect bypasses the credit check because the
  // flush releases every credit in the same cycle.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = pc;
    if (!reset && state == RUN) begin
      if (redir) begin
        mem_en   = ~misalign;
        mem_addr = redir_tgt;
      end else begin
        mem_en   = credit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_PC;
      occ     <= 2'd0;
      vld_p1  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (redir && misalign) begin
            state   <= HALT;
            fault_r <= 1'b1;
            occ     <= 2'd0;
            vld_p1  <= 1'b0;
          end else begin
            // A redirect discards the FIFO and the returning word alike.
            occ    <= redir ? 2'd0 : occ_pop + {1'b0, vld_p1};
            vld_p1 <= mem_en;
            if (mem_en) pc <= next_pc;
          end
        end
        HALT: begin
          occ    <= 2'd0;
          vld_p1 <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Stage p1: response capture into the FIFO tail (shift-on-pop FIFO, head
  // in slot 0). The tail write overrides the shift when both hit slot 0.
  always_ff @(posedge clk) begin
    if (mem_en) pc_p1 <= mem_addr;
    if (pop) begin
      q_data[0] <= q_data[1];
      q_pc[0]   <= q_pc[1];
    end
    if (vld_p1) begin
      if (occ_pop == 2'd0) begin
        q_data[0] <= mem_rdata;
        q_pc[0]   <= pc_p1;
      end else begin
        q_data[1] <= mem_rdata;
        q_pc[1]   <= pc_p1;
      end
    end
  end

  // Stage p2: decode-facing head; data fields read as zero when empty so
  // they need no reset of their own.
  assign inst_valid = (occ != 2'd0);
  assign inst_data  = inst_valid ? q_data[0] : 32'd0;
  assign inst_pc    = inst_valid ? q_pc[0]   : 32'd0;
  assign fault      = fault_r;

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the single-cycle-latency instruction memory of the RV32 core. It owns the program counter, issues one read per cycle to IMEM, and buffers returned words in a 2-entry queue. Each word leaves through a valid/ready handshake to decode. Taken branches and jumps arrive as a redirect that flushes the queue and squashes the in-flight read.

## Interface
- RESET_PC, default 32'h0000_0000: first fetch address after reset.
- IMEM_BYTES, default 128: IMEM size in bytes, a power of two; the PC wraps modulo this value.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- mem_en  out  1  IMEM read strobe for this cycle.
- mem_addr  out  32  byte address of the read; always a multiple of 4.
- mem_rdata  in  32  IMEM data; valid in the cycle after mem_en.
- redirect_valid  in  1  single-cycle request to restart fetch.
- redirect_pc  in  32  restart target address.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  32  instruction at the queue head.
- inst_pc  out  32  address of inst_data.
- fault  out  1  sticky misaligned-redirect flag; see Configuration.

## Operation
- State machine:
  - RUN: normal fetch.
  - HALT: fault taken; only reset exits it.
  - Reset always enters RUN.
- Credit rule: issue a read (mem_en=1, mem_addr=pc) when occ + inflight − pop < 2.
  - occ = queue entries (0..2).
  - inflight = read issued in the previous cycle and not squashed.
  - pop = inst_valid && inst_ready.
- On issue, pc ← (pc + 4) mod IMEM_BYTES. The wrap goes from IMEM_BYTES−4 to 0.
- A response (inflight=1) is written into the queue tail with its address at the clock edge that ends the cycle in which it is valid.
- The queue is FIFO. inst_data/inst_pc show the head, and are held stable while inst_valid && !inst_ready.
- Redirect cycle:
  - Queue is flushed, and mem_rdata returned this cycle is discarded.
  - A read to redirect_pc (masked to 4-byte alignment, modulo IMEM_BYTES) is issued in the same cycle.
  - pc ← that address + 4.
- Redirect together with pop: the transfer counts as completed for decode; the flush then removes everything remaining.
- Redirect ignores the credit rule, because the flush frees all credits.
- In HALT: mem_en=0, queue empty, inst_valid=0, redirect ignored.

## Timing
- Values during and on the cycle after reset:
  - mem_en=0, mem_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - fault=0; pc=RESET_PC, occ=0, inflight=0.
- First cycle with reset low: mem_en=1, mem_addr=RESET_PC. inst_valid rises two cycles later.
- Redirect asserted in cycle N: the instruction at redirect_pc is presented with inst_valid=1 in cycle N+2.
- Throughput: with inst_ready held high, one instruction per cycle sustained after the 2-cycle fill.
- Backpressure: with inst_ready low, at most 2 entries are held and issue stops. Full rate resumes one cycle after ready returns, with no lost or duplicated words.
- Reset mid-operation discards the queue, any in-flight read and fault on the same edge.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]≠0 flushes the queue, issues no read and sets fault=1 from the next cycle.
  - The block then enters HALT until reset.
  - The valid/ready state visible to decode equals that of an ordinary flush.
- IFETCH_MISALIGN_TRAP_EN undefined:
  - redirect_pc[1:0] is ignored (forced to 00).
  - fault is tied to 0 and HALT is unreachable.

## Test plan
- Reset release with RESET_PC=0 and inst_ready=1: mem_addr 0,4,8,… on consecutive cycles. inst_pc 0,4,8 with matching IMEM words, first inst_valid 2 cycles after release.
- inst_ready low for 5 cycles from inst_pc=8: queue holds pcs 8 and 12, mem_en low after fill, inst_data stable. On release, 8,12,16,… delivered with no gaps beyond one cycle and no duplicates.
- Redirect to 0x40 while the queue holds 2 entries and a read is in flight: next inst_valid shows inst_pc=0x40 two cycles later, and neither stale entry nor the squashed read appears.
- PC at IMEM_BYTES−4 (0x7C for 128): the following fetch address is 0x00.
- Redirect to 0x22:
  - With IFETCH_MISALIGN_TRAP_EN: fault=1, mem_en stays 0, inst_valid stays 0 until reset, and a later redirect is ignored.
  - Without it: fetch resumes at 0x20.
- Redirect in the same cycle as pop of pc 0x10: 0x10 counts as accepted, and the next delivered pc is the redirect target.
